dsram_bridge: RTL and testbench

//  Responder end of the CPU data-SRAM interface. Serves data_sram_en/wen/addr/wdata

---
 rtl/dsram_bridge_if.sv | 25 ++
 rtl/dsram_bridge.sv | 169 ++++++++++++++++
 tb/tb_dsram_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dsram_bridge_if.sv
// Variable-latency memory port driven by dsram_bridge: req/addr_ok request
// handshake followed by a data_ok completion.
interface dsram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req;
  logic              we;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, we, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dsram_bridge.sv
// CPU data-SRAM responder: one outstanding access forwarded to a req/addr_ok/data_ok port.
// Define DSRAM_WBUF_EN to add a one-entry posted write buffer.
module dsram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq,
  dsram_bridge_if.master    mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        wstrb_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              stall_reg, stall_next;
  logic              take_cpu;
  logic              complete;

`ifdef DSRAM_WBUF_EN
  // While wb_valid_reg is set the access registers hold the posted store.
  logic              wb_valid_reg, wb_valid_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [3:0]        pend_wstrb_reg;
  logic [ADDR_W-1:0] pend_addr_reg;
  logic [DATA_W-1:0] pend_wdata_reg;
  logic              take_pend, pend_set, wb_set, wb_clr;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    take_cpu   = 1'b0;
    complete   = 1'b0;
`ifdef DSRAM_WBUF_EN
    take_pend  = 1'b0;
    pend_set   = 1'b0;
    wb_set     = 1'b0;
    wb_clr     = 1'b0;
`endif
    case (state_reg)
      IDLE, DONE: begin
`ifdef DSRAM_WBUF_EN
        if (wb_valid_reg && state_reg == IDLE) begin
          state_next = REQ;
          if (data_sram_en && !pend_valid_reg) pend_set = 1'b1;
        end else begin
          if (state_reg == DONE && wb_valid_reg) wb_clr = 1'b1;
          if (pend_valid_reg) begin
            take_pend  = 1'b1;
            state_next = REQ;
          end else if (data_sram_en) begin
            take_cpu = 1'b1;
            if (|data_sram_wen) begin
              wb_set     = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = REQ;
            end
          end else begin
            state_next = IDLE;
          end
        end
`else
        if (data_sram_en) begin
          take_cpu   = 1'b1;
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
`endif
      end
      REQ: begin
        if (mem.addr_ok) begin
          if (mem.data_ok) begin
            complete   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT;
          end
        end
`ifdef DSRAM_WBUF_EN
        if (wb_valid_reg && data_sram_en && !pend_valid_reg) pend_set = 1'b1;
`endif
      end
      WAIT: begin
        if (mem.data_ok) begin
          complete   = 1'b1;
          state_next = DONE;
        end
`ifdef DSRAM_WBUF_EN
        if (wb_valid_reg && data_sram_en && !pend_valid_reg) pend_set = 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase

`ifdef DSRAM_WBUF_EN
    wb_valid_next   = wb_set ? 1'b1 : (wb_clr ? 1'b0 : wb_valid_reg);
    pend_valid_next = pend_set ? 1'b1 : (take_pend ? 1'b0 : pend_valid_reg);
    // A buffer drain is invisible to the CPU; only a queued access stalls it.
    stall_next = ((state_next == REQ || state_next == WAIT) && !wb_valid_next)
                 || pend_valid_next;
`else
    stall_next = (state_next == REQ || state_next == WAIT);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstrb_reg      <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      stall_reg      <= 1'b0;
`ifdef DSRAM_WBUF_EN
      wb_valid_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_wstrb_reg <= '0;
      pend_addr_reg  <= '0;
      pend_wdata_reg <= '0;
`endif
    end else begin
      if (take_cpu) begin
        wstrb_reg <= data_sram_wen;
        addr_reg  <= data_sram_addr;
        wdata_reg <= data_sram_wdata;
      end
`ifdef DSRAM_WBUF_EN
      else if (take_pend) begin
        wstrb_reg <= pend_wstrb_reg;
        addr_reg  <= pend_addr_reg;
        wdata_reg <= pend_wdata_reg;
      end
      if (pend_set) begin
        pend_wstrb_reg <= data_sram_wen;
        pend_addr_reg  <= data_sram_addr;
        pend_wdata_reg <= data_sram_wdata;
      end
      wb_valid_reg   <= wb_valid_next;
      pend_valid_reg <= pend_valid_next;
`endif
      if (complete && wstrb_reg == 4'b0000) rdata_reg <= mem.rdata;
      stall_reg <= stall_next;
    end
  end

  assign mem.req         = (state_reg == REQ);
  assign mem.we          = |wstrb_reg;
  assign mem.wstrb       = wstrb_reg;
  assign mem.addr        = addr_reg;
  assign mem.wdata       = wdata_reg;
  assign data_sram_rdata = rdata_reg;
  assign stallreq        = stall_reg;

endmodule

// File: tb/tb_dsram_bridge.sv
// Directed-vector bench for dsram_bridge; the memory side is driven cycle by cycle
// from the stimulus, and every expected value is a hand-computed constant.
module tb_dsram_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'b0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic        stallreq;

  int vectors = 0;
  int miscompares = 0;

  dsram_bridge_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  dsram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .mem             (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One CPU access: addr_ok arrives in REQ cycle a_lat (1-based), data_ok d_lat cycles later.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int a_lat, input int d_lat,
                        output int stall_cnt, output logic req_after,
                        output logic we0, output logic [3:0] wstrb0,
                        output logic [31:0] addr0, output logic [31:0] wdata0);
    int k;
    stall_cnt = 0;
    req_after = 1'b0;
    @(negedge clk);
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    mem_if.rdata    = rd;
    k = 0;
    forever begin
      @(negedge clk);
      if (k == 0) begin
        data_sram_en = 1'b0;
        we0    = mem_if.we;
        wstrb0 = mem_if.wstrb;
        addr0  = mem_if.addr;
        wdata0 = mem_if.wdata;
      end
      if (k == a_lat) req_after = mem_if.req;
      if (!stallreq) break;
      stall_cnt++;
      mem_if.addr_ok = (k == a_lat - 1);
      mem_if.data_ok = (k == a_lat - 1 + d_lat);
      k++;
      if (k > 40) begin
        check_val("access_timeout", 32'(k), 32'd0);
        break;
      end
    end
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
  endtask

  initial begin
    int          sc;
    logic        ra, we0;
    logic [3:0]  ws0;
    logic [31:0] a0, w0;
    int          nreq;
    logic [31:0] addr2;

    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = '0;

    #2 resetn = 1'b0;
    #1;
    check_val("rst_stallreq", 32'(stallreq), 32'd0);
    check_val("rst_mem_req", 32'(mem_if.req), 32'd0);
    check_val("rst_rdata", data_sram_rdata, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // 1: single-cycle read
    access(4'b0000, 32'h40, 32'h0, 32'hDEADBEEF, 1, 0, sc, ra, we0, ws0, a0, w0);
    check_val("t1_stall_cycles", 32'(sc), 32'd1);
    check_val("t1_rdata", data_sram_rdata, 32'hDEADBEEF);
    check_val("t1_mem_addr", a0, 32'h40);
    check_val("t1_mem_we", 32'(we0), 32'd0);

    // 2: addr_ok in third REQ cycle, data_ok two cycles later
    access(4'b0000, 32'h44, 32'h0, 32'h11112222, 3, 2, sc, ra, we0, ws0, a0, w0);
    check_val("t2_stall_cycles", 32'(sc), 32'd5);
    check_val("t2_req_after_addr_ok", 32'(ra), 32'd0);
    check_val("t2_rdata", data_sram_rdata, 32'h11112222);

`ifndef DSRAM_WBUF_EN
    // 3: store stalls like a load and leaves rdata alone
    access(4'b0011, 32'h80, 32'h1234, 32'hFFFFFFFF, 1, 0, sc, ra, we0, ws0, a0, w0);
    check_val("t3_mem_we", 32'(we0), 32'd1);
    check_val("t3_mem_wstrb", 32'(ws0), 32'h3);
    check_val("t3_mem_addr", a0, 32'h80);
    check_val("t3_mem_wdata", w0, 32'h1234);
    check_val("t3_stall_cycles", 32'(sc), 32'd1);
    check_val("t3_rdata_kept", data_sram_rdata, 32'h11112222);
`endif

    // 4: back-to-back reads, EX keeps en high through the stall
    @(negedge clk);
    nreq = 0;
    addr2 = '0;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0;
    data_sram_addr = 32'h100;
    mem_if.rdata   = 32'hCAFE0100;
    mem_if.addr_ok = 1'b1;
    mem_if.data_ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_if.req) begin
        nreq++;
        if (nreq == 1) data_sram_addr = 32'h104;
        if (nreq == 2) begin
          check_val("t4_rdata_first", data_sram_rdata, 32'hCAFE0100);
          addr2 = mem_if.addr;
          data_sram_en = 1'b0;
          mem_if.rdata = 32'hCAFE0104;
        end
      end
    end
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    check_val("t4_req_count", 32'(nreq), 32'd2);
    check_val("t4_second_addr", addr2, 32'h104);
    check_val("t4_rdata_second", data_sram_rdata, 32'hCAFE0104);

    // 5: reset while waiting for data_ok
    @(negedge clk);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0;
    data_sram_addr = 32'h200;
    mem_if.rdata   = 32'h55555555;
    @(negedge clk);
    data_sram_en   = 1'b0;
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    mem_if.addr_ok = 1'b0;
    check_val("t5_wait_stall", 32'(stallreq), 32'd1);
    check_val("t5_wait_req", 32'(mem_if.req), 32'd0);
    #1 resetn = 1'b0;
    #1;
    check_val("t5_rst_stallreq", 32'(stallreq), 32'd0);
    check_val("t5_rst_mem_req", 32'(mem_if.req), 32'd0);
    check_val("t5_rst_rdata", data_sram_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    mem_if.data_ok = 1'b0;
    @(negedge clk);
    check_val("t5_stray_stall", 32'(stallreq), 32'd0);
    check_val("t5_stray_req", 32'(mem_if.req), 32'd0);
    check_val("t5_stray_rdata", data_sram_rdata, 32'h0);

`ifdef DSRAM_WBUF_EN
    // 6: posted store followed by a load that waits for the drain
    @(negedge clk);
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'b1111;
    data_sram_addr  = 32'h300;
    data_sram_wdata = 32'h77;
    mem_if.rdata    = 32'h99;
    mem_if.addr_ok  = 1'b1;
    mem_if.data_ok  = 1'b1;
    @(negedge clk);
    check_val("t6_store_stall", 32'(stallreq), 32'd0);
    check_val("t6_store_req", 32'(mem_if.req), 32'd0);
    data_sram_wen  = 4'b0;
    data_sram_addr = 32'h304;
    @(negedge clk);
    data_sram_en = 1'b0;
    check_val("t6_drain_req", 32'(mem_if.req), 32'd1);
    check_val("t6_drain_addr", mem_if.addr, 32'h300);
    check_val("t6_drain_we", 32'(mem_if.we), 32'd1);
    check_val("t6_load_stall_a", 32'(stallreq), 32'd1);
    @(negedge clk);
    check_val("t6_load_stall_b", 32'(stallreq), 32'd1);
    @(negedge clk);
    check_val("t6_load_req", 32'(mem_if.req), 32'd1);
    check_val("t6_load_addr", mem_if.addr, 32'h304);
    check_val("t6_load_we", 32'(mem_if.we), 32'd0);
    @(negedge clk);
    check_val("t6_load_done_stall", 32'(stallreq), 32'd0);
    check_val("t6_load_rdata", data_sram_rdata, 32'h99);
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
